// File: rtl/sprite_line_writer.sv
// Rasterises the cached sprites for one scanline into the line buffer, farthest first (SPRITE_TRANSPARENCY_EN skips index-0 texels).
// Latency: done 1 cycle after start if empty; else 1 + per sprite (2+span+1 drawn, 3 skipped), done pulse follows.
// Backpressure: none; sprite cache and texture ROM are fixed one-cycle reads, one pixel issued per cycle.
module sprite_line_writer #(
  parameter int WIDTH       = 320,
  parameter int MAX_SPRITES = 8,
  parameter int TEX_BITS    = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         done,
  input  logic [8:0]   y,
  input  logic [3:0]   sprite_count,
  output logic [2:0]   sprite_addr,
  input  logic [119:0] sprite_meta,
  output logic [19:0]  tex_addr,
  input  logic [7:0]   tex_data,
  output logic [8:0]   lb_waddr,
  output logic [7:0]   lb_wdata,
  output logic         lb_we
);

  typedef struct packed {
    logic [7:0]  tex_id;
    logic [15:0] z;
    logic [15:0] y_top;
    logic [15:0] height;
    logic [15:0] u_step;
    logic [15:0] v_step;
    logic [15:0] x_start;
    logic [15:0] x_end;
  } meta_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    DRAW,
    DRAIN,
    NEXT,
    DONE
  } state_t;

  localparam logic signed [15:0] XMAX    = 16'(WIDTH - 1);
  localparam logic [TEX_BITS-1:0] ROW_MAX = '1;
  localparam logic [3:0]          CNT_MAX = 4'(MAX_SPRITES);

  state_t state, state_next;

  meta_t                 meta;
  logic [3:0]            cnt_clamped;
  logic [2:0]            idx_init;
  logic signed [16:0]    dy;
  logic                  skip_row;
  logic [31:0]           row_prod;
  logic [31:0]           row_shift;
  logic [TEX_BITS-1:0]   row_sat;
  logic signed [15:0]    x_start_s;
  logic signed [15:0]    x_end_s;
  logic signed [15:0]    xs;
  logic signed [15:0]    xe;
  logic                  skip_clip;
  logic [16:0]           x_off;
  logic [23:0]           u_init;
  logic                  pix_keep;
  logic                  unused_meta_z;

  logic [2:0]            idx;
  logic [7:0]            tex_id_q;
  logic [TEX_BITS-1:0]   row_q;
  logic [23:0]           u_q;
  logic [15:0]           u_step_q;
  logic [8:0]            x_q;
  logic [8:0]            xe_q;
  logic [8:0]            x_pipe;
  logic                  pipe_vld;

  assign meta          = sprite_meta;
  assign unused_meta_z = ^meta.z;

  assign cnt_clamped = (sprite_count > CNT_MAX) ? CNT_MAX : sprite_count;
  assign idx_init    = 3'(cnt_clamped - 4'd1);

  // Row test: y is unsigned, y_top signed; 17 bits holds every difference.
  assign dy        = $signed({8'd0, y}) - $signed({meta.y_top[15], meta.y_top});
  assign skip_row  = dy[16] | (dy[15:0] >= meta.height);
  assign row_prod  = 32'(dy[15:0]) * 32'(meta.v_step);
  assign row_shift = row_prod >> 8;
  assign row_sat   = (row_shift > 32'(ROW_MAX)) ? ROW_MAX : row_shift[TEX_BITS-1:0];

  assign x_start_s = $signed(meta.x_start);
  assign x_end_s   = $signed(meta.x_end);
  assign xs        = x_start_s[15] ? 16'sd0 : x_start_s;
  assign xe        = (x_end_s > XMAX) ? XMAX : x_end_s;
  assign skip_clip = (xs > xe);

  // Left-clipped sprites start mid-texture: advance u by the hidden pixels.
  assign x_off  = {xs[15], xs} - {x_start_s[15], x_start_s};
  assign u_init = 24'(x_off) * {8'd0, meta.u_step};

`ifdef SPRITE_TRANSPARENCY_EN
  assign pix_keep = (tex_data != 8'h00);
`else
  assign pix_keep = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN makes the next-sprite decision itself so a drawn sprite costs 2+span+1.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (cnt_clamped == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD:  state_next = (skip_row || skip_clip) ? NEXT : DRAW;
      DRAW:  state_next = (x_q == xe_q) ? DRAIN : DRAW;
      DRAIN, NEXT: state_next = (idx == 3'd0) ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done        = (state == DONE);
    sprite_addr = idx;
    tex_addr    = {tex_id_q, row_q, u_q[8+TEX_BITS-1:8]};
    lb_we       = pipe_vld & pix_keep;
    lb_waddr    = x_pipe;
    lb_wdata    = lb_we ? tex_data : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      tex_id_q <= '0;
      row_q    <= '0;
      u_q      <= '0;
      u_step_q <= '0;
      x_q      <= '0;
      xe_q     <= '0;
      x_pipe   <= '0;
      pipe_vld <= 1'b0;
    end else begin
      pipe_vld <= (state == DRAW);
      unique case (state)
        IDLE: begin
          if (start && cnt_clamped != 4'd0) begin
            idx <= idx_init;
          end
        end
        LOAD: begin
          tex_id_q <= meta.tex_id;
          row_q    <= row_sat;
          u_q      <= u_init;
          u_step_q <= meta.u_step;
          x_q      <= xs[8:0];
          xe_q     <= xe[8:0];
        end
        DRAW: begin
          x_pipe <= x_q;
          x_q    <= x_q + 9'd1;
          u_q    <= u_q + {8'd0, u_step_q};
        end
        DRAIN, NEXT: begin
          if (idx != 3'd0) begin
            idx <= idx - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_writer.sv
// Directed bench for sprite_line_writer with a sprite-cache and texture-ROM model.
module tb_sprite_line_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done;
  logic [8:0]   y;
  logic [3:0]   sprite_count;
  logic [2:0]   sprite_addr;
  logic [119:0] sprite_meta;
  logic [19:0]  tex_addr;
  logic [7:0]   tex_data;
  logic [8:0]   lb_waddr;
  logic [7:0]   lb_wdata;
  logic         lb_we;

  always #5 clk = ~clk;

  sprite_line_writer dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .y(y),
    .sprite_count(sprite_count), .sprite_addr(sprite_addr), .sprite_meta(sprite_meta),
    .tex_addr(tex_addr), .tex_data(tex_data), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .lb_we(lb_we)
  );

  typedef struct {
    logic [8:0]  a;
    logic [7:0]  d;
    logic [19:0] ta;
  } wr_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic bad_addr = 1'b0;
  logic [19:0] prev_ta = '0;
  wr_t mon_e;
  wr_t log[$];

  logic [119:0] meta_mem [8];
  logic         tex_mode = 1'b0;   // 0: texel = col - tex_bias, 1: texel = tex_id
  logic [7:0]   tex_bias = 8'hF0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    sprite_meta <= meta_mem[sprite_addr];
    tex_data    <= tex_mode ? tex_addr[19:12] : ({2'b00, tex_addr[5:0]} - tex_bias);
  end

  // A write retires one cycle after its texture address was issued.
  always @(negedge clk) begin
    if (lb_we) begin
      mon_e.a  = lb_waddr;
      mon_e.d  = lb_wdata;
      mon_e.ta = prev_ta;
      log.push_back(mon_e);
      if (lb_waddr >= 9'd320) bad_addr = 1'b1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    prev_ta = tex_addr;
  end

  function automatic logic [119:0] mk(input logic [7:0] id, input logic [15:0] yt, input logic [15:0] h,
                                      input logic [15:0] us, input logic [15:0] vs,
                                      input logic [15:0] xs, input logic [15:0] xe);
    return {id, 16'h0000, yt, h, us, vs, xs, xe};
  endfunction

  task automatic run_line(input logic [8:0] yy, input logic [3:0] cnt, input int restart_at,
                          output int lat, output logic [2:0] ff, output int ndone);
    int k;
    int d0;
    y = yy;
    sprite_count = cnt;
    log.delete();
    bad_addr = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    ff = sprite_addr;
    lat = -1;
    for (int n = 0; n < 300 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
      start = (restart_at != 0) && (cyc - k == restart_at);
    end
    start = 1'b0;
    if (done_cnt != d0) lat = done_cyc - k;
    repeat (12) @(posedge clk);
    #1;
    ndone = done_cnt - d0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; y = '0; sprite_count = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (lb_we !== 1'b0) begin failures++; $display("FAIL reset_lb_we: got %b want 0", lb_we); end
    checks++;
    if ({sprite_addr, tex_addr, lb_waddr, lb_wdata} !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs: sprite_addr=%0h tex_addr=%0h lb_waddr=%0h lb_wdata=%0h want all 0",
               sprite_addr, tex_addr, lb_waddr, lb_wdata);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || lb_we !== 1'b0) begin
      failures++; $display("FAIL idle_quiet: done=%b lb_we=%b want 0 0", done, lb_we);
    end
  endtask

  task automatic test_empty();
    int lat; logic [2:0] ff; int nd;
    run_line(9'd5, 4'd0, 0, lat, ff, nd);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL empty_latency: got %0d want 1", lat); end
    checks++;
    if (log.size() !== 0) begin failures++; $display("FAIL empty_writes: got %0d want 0", log.size()); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL empty_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_single(input int restart_at);
    int lat; logic [2:0] ff; int nd;
    tex_mode = 1'b0; tex_bias = 8'hF0;
    meta_mem[0] = mk(8'h05, 16'd0, 16'd64, 16'h0100, 16'h0100, 16'd10, 16'd13);
    run_line(9'd5, 4'd1, restart_at, lat, ff, nd);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL single_latency: got %0d want 8", lat); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL single_done_count: got %0d want 1", nd); end
    checks++;
    if (log.size() !== 4) begin failures++; $display("FAIL single_writes: got %0d want 4", log.size()); end
    for (int i = 0; i < 4 && i < log.size(); i++) begin
      checks++;
      if (log[i].a !== 9'(10 + i) || log[i].d !== 8'(8'h10 + i) || log[i].ta !== 20'(20'h05140 + i)) begin
        failures++;
        $display("FAIL single_pix%0d: got a=%0d d=%0h ta=%0h want a=%0d d=%0h ta=%0h",
                 i, log[i].a, log[i].d, log[i].ta, 10 + i, 8'h10 + i, 20'h05140 + i);
      end
    end
  endtask

  task automatic test_clip_left();
    int lat; logic [2:0] ff; int nd;
    tex_mode = 1'b0; tex_bias = 8'hF0;
    meta_mem[0] = mk(8'h06, 16'd0, 16'd64, 16'h0200, 16'h0100, 16'hFFFC, 16'd2);
    run_line(9'd5, 4'd1, 0, lat, ff, nd);
    checks++;
    if (lat !== 7) begin failures++; $display("FAIL clipl_latency: got %0d want 7", lat); end
    checks++;
    if (log.size() !== 3) begin failures++; $display("FAIL clipl_writes: got %0d want 3", log.size()); end
    for (int i = 0; i < 3 && i < log.size(); i++) begin
      checks++;
      if (log[i].a !== 9'(i) || log[i].d !== 8'(8'h18 + 2 * i) || log[i].ta !== 20'(20'h06148 + 2 * i)) begin
        failures++;
        $display("FAIL clipl_pix%0d: got a=%0d d=%0h ta=%0h want a=%0d d=%0h ta=%0h",
                 i, log[i].a, log[i].d, log[i].ta, i, 8'h18 + 2 * i, 20'h06148 + 2 * i);
      end
    end
  endtask

  task automatic test_overlap();
    int lat; logic [2:0] ff; int nd;
    logic [7:0] first50; logic [7:0] last50; logic seen;
    tex_mode = 1'b1;
    meta_mem[1] = mk(8'h11, 16'd0, 16'd64, 16'h0100, 16'h0100, 16'd45, 16'd55);
    meta_mem[0] = mk(8'h22, 16'd0, 16'd64, 16'h0100, 16'h0100, 16'd50, 16'd60);
    run_line(9'd5, 4'd2, 0, lat, ff, nd);
    seen = 1'b0; first50 = '0; last50 = '0;
    foreach (log[i]) begin
      if (log[i].a == 9'd50) begin
        if (!seen) first50 = log[i].d;
        seen = 1'b1;
        last50 = log[i].d;
      end
    end
    checks++;
    if (ff !== 3'd1) begin failures++; $display("FAIL overlap_first_fetch: got %0d want 1", ff); end
    checks++;
    if (lat !== 29) begin failures++; $display("FAIL overlap_latency: got %0d want 29", lat); end
    checks++;
    if (log.size() !== 22) begin failures++; $display("FAIL overlap_writes: got %0d want 22", log.size()); end
    checks++;
    if (first50 !== 8'h11) begin failures++; $display("FAIL overlap_first50: got %0h want 11", first50); end
    checks++;
    if (last50 !== 8'h22) begin failures++; $display("FAIL overlap_last50: got %0h want 22", last50); end
  endtask

  task automatic test_skip_and_clip_right();
    int lat; logic [2:0] ff; int nd;
    tex_mode = 1'b0; tex_bias = 8'hF0;
    meta_mem[1] = mk(8'h44, 16'd0, 16'd50, 16'h0100, 16'h0100, 16'd0, 16'd10);
    meta_mem[0] = mk(8'h55, 16'd0, 16'd200, 16'h0100, 16'h0100, 16'd300, 16'd400);
    run_line(9'd100, 4'd2, 0, lat, ff, nd);
    checks++;
    if (lat !== 27) begin failures++; $display("FAIL skip_latency: got %0d want 27", lat); end
    checks++;
    if (log.size() !== 20) begin failures++; $display("FAIL skip_writes: got %0d want 20", log.size()); end
    if (log.size() == 20) begin
      checks++;
      if (log[0].a !== 9'd300 || log[0].ta !== 20'h55FC0) begin
        failures++;
        $display("FAIL skip_first: got a=%0d ta=%0h want a=300 ta=55fc0", log[0].a, log[0].ta);
      end
      checks++;
      if (log[19].a !== 9'd319 || log[19].d !== 8'h23) begin
        failures++;
        $display("FAIL clipr_last: got a=%0d d=%0h want a=319 d=23", log[19].a, log[19].d);
      end
    end
    checks++;
    if (bad_addr !== 1'b0) begin failures++; $display("FAIL addr_range: got %b want 0", bad_addr); end
  endtask

  task automatic test_clamp();
    int lat; logic [2:0] ff; int nd;
    tex_mode = 1'b1;
    for (int i = 1; i < 8; i++) meta_mem[i] = mk(8'h44, 16'd0, 16'd0, 16'h0100, 16'h0100, 16'd0, 16'd10);
    meta_mem[0] = mk(8'h33, 16'd0, 16'd64, 16'h0100, 16'h0100, 16'd5, 16'd5);
    run_line(9'd5, 4'd12, 0, lat, ff, nd);
    checks++;
    if (ff !== 3'd7) begin failures++; $display("FAIL clamp_first_fetch: got %0d want 7", ff); end
    checks++;
    if (lat !== 26) begin failures++; $display("FAIL clamp_latency: got %0d want 26", lat); end
    checks++;
    if (log.size() !== 1 || (log.size() == 1 && (log[0].a !== 9'd5 || log[0].d !== 8'h33))) begin
      failures++; $display("FAIL clamp_write: got %0d writes want 1 write a=5 d=33", log.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0; int n;
    tex_mode = 1'b0; tex_bias = 8'hF0;
    meta_mem[0] = mk(8'h07, 16'd0, 16'd64, 16'h0100, 16'h0100, 16'd10, 16'd40);
    y = 9'd5; sprite_count = 4'd1; d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (lb_we !== 1'b1) begin failures++; $display("FAIL rstmid_drawing: got lb_we=%b want 1", lb_we); end
    rst = 1'b1;
    #1;
    checks++;
    if (lb_we !== 1'b0) begin failures++; $display("FAIL rstmid_we_drop: got %b want 0", lb_we); end
    n = log.size();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0) begin failures++; $display("FAIL rstmid_no_done: got %0d dones want 0", done_cnt - d0); end
    checks++;
    if (log.size() !== n) begin failures++; $display("FAIL rstmid_no_writes: got %0d writes want %0d", log.size(), n); end
  endtask

  task automatic test_transparency();
    int lat; logic [2:0] ff; int nd;
    tex_mode = 1'b0; tex_bias = 8'h02;   // texels FE FF 00 01 across x 10..13
    meta_mem[0] = mk(8'h08, 16'd0, 16'd64, 16'h0100, 16'h0100, 16'd10, 16'd13);
    run_line(9'd5, 4'd1, 0, lat, ff, nd);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL transp_latency: got %0d want 8", lat); end
`ifdef SPRITE_TRANSPARENCY_EN
    checks++;
    if (log.size() !== 3) begin failures++; $display("FAIL transp_writes: got %0d want 3", log.size()); end
    if (log.size() == 3) begin
      checks++;
      if (log[0].a !== 9'd10 || log[1].a !== 9'd11 || log[2].a !== 9'd13 || log[2].d !== 8'h01) begin
        failures++;
        $display("FAIL transp_addrs: got %0d %0d %0d d=%0h want 10 11 13 d=01",
                 log[0].a, log[1].a, log[2].a, log[2].d);
      end
    end
`else
    checks++;
    if (log.size() !== 4) begin failures++; $display("FAIL opaque_writes: got %0d want 4", log.size()); end
    if (log.size() == 4) begin
      checks++;
      if (log[2].a !== 9'd12 || log[2].d !== 8'h00 || log[0].d !== 8'hFE) begin
        failures++;
        $display("FAIL opaque_zero: got a=%0d d=%0h first=%0h want a=12 d=00 first=fe",
                 log[2].a, log[2].d, log[0].d);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single(0);
    test_clip_left();
    test_overlap();
    test_skip_and_clip_right();
    test_clamp();
    test_single(4);   // start re-pulsed mid-draw must be ignored
    test_reset_mid();
    test_transparency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
